// File: rtl/bridge_pkg.sv
// Shared state encoding, default decode region and packed-parameter slicing for wait_bridge.
package bridge_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [23:0] REGION_DEFAULT = 24'h00007F;

  localparam int unsigned MAX_DEC_W  = 16;
  localparam int unsigned MAX_PACK_W = 128;

  // Extract field idx (each w bits wide) from a packed per-device parameter vector.
  function automatic logic [MAX_DEC_W-1:0] field_slice(input logic [MAX_PACK_W-1:0] packed_v,
                                                       input int unsigned idx,
                                                       input int unsigned w);
    logic [MAX_PACK_W-1:0] shifted;
    logic [MAX_PACK_W-1:0] keep;
    shifted = packed_v >> (idx * w);
    keep    = (MAX_PACK_W'(1) << w) - MAX_PACK_W'(1);
    return MAX_DEC_W'(shifted & keep);
  endfunction

endpackage

// File: rtl/addr_decoder.sv
// Combinational window decode: one-hot hit vector with lowest-index priority.
module addr_decoder
  import bridge_pkg::*;
#(
  parameter int unsigned             N_DEV    = 4,
  parameter int unsigned             DEC_W    = 8,
  parameter logic [31:0]             REGION   = 32'(REGION_DEFAULT),
  parameter logic [N_DEV*DEC_W-1:0]  DEV_BASE = {8'h60, 8'h40, 8'h20, 8'h00},
  parameter logic [N_DEV*DEC_W-1:0]  DEV_MASK = {8'hE0, 8'hE0, 8'hE0, 8'hE0}
) (
  input  logic [31:0]      pr_addr,
  output logic [N_DEV-1:0] hit_oh_c,
  output logic             any_hit_c
);

  logic             region_ok;
  logic [DEC_W-1:0] base_i;
  logic [DEC_W-1:0] mask_i;
  logic             found;

  assign region_ok = ((pr_addr >> DEC_W) == REGION);

  always_comb begin
    hit_oh_c = '0;
    found    = 1'b0;
    base_i   = '0;
    mask_i   = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      base_i = DEC_W'(field_slice(MAX_PACK_W'(DEV_BASE), i, DEC_W));
      mask_i = DEC_W'(field_slice(MAX_PACK_W'(DEV_MASK), i, DEC_W));
      if (!found && region_ok && ((pr_addr[DEC_W-1:0] & mask_i) == base_i)) begin
        hit_oh_c[i] = 1'b1;
        found       = 1'b1;
      end
    end
    any_hit_c = found;
  end

endmodule

// File: rtl/wait_bridge.sv
// CPU-to-peripheral bridge with per-device wait-state ack, bounded timeout and irq synchroniser.
module wait_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned             N_DEV    = 4,
  parameter int unsigned             DEC_W    = 8,
  parameter logic [31:0]             REGION   = 32'(REGION_DEFAULT),
  parameter logic [N_DEV*DEC_W-1:0]  DEV_BASE = {8'h60, 8'h40, 8'h20, 8'h00},
  parameter logic [N_DEV*DEC_W-1:0]  DEV_MASK = {8'hE0, 8'hE0, 8'hE0, 8'hE0},
  parameter int unsigned             TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pr_req,
  input  logic [31:0]           pr_addr,
  input  logic [31:0]           pr_wd,
  input  logic                  pr_we,
  input  logic [3:0]            pr_be,
  output logic [31:0]           pr_rd,
  output logic                  pr_ready,
  output logic                  pr_err,
  output logic [N_DEV-1:0]      dev_sel,
  output logic                  dev_we,
  output logic [DEC_W-3:0]      dev_addr,
  output logic [31:0]           dev_wd,
  output logic [3:0]            dev_be,
  input  logic [N_DEV*32-1:0]   dev_rd,
  input  logic [N_DEV-1:0]      dev_ack,
  input  logic [N_DEV-1:0]      dev_irq,
  output logic [N_DEV-1:0]      hw_int
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned AW    = DEC_W - 2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_DEV-1:0] sel_q, sel_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wd_q, wd_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rd_q, rd_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic [N_DEV-1:0] sync1_q, sync2_q;

  logic [N_DEV-1:0] hit_oh_c;
  logic             any_hit_c;
  logic             sel_ack;
  logic [31:0]      sel_rd;

  addr_decoder #(
    .N_DEV    (N_DEV),
    .DEC_W    (DEC_W),
    .REGION   (REGION),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_dec (
    .pr_addr   (pr_addr),
    .hit_oh_c  (hit_oh_c),
    .any_hit_c (any_hit_c)
  );

  // Only the selected channel's ack and read data are ever observed.
  assign sel_ack = |(dev_ack & sel_q);

  always_comb begin
    sel_rd = '0;
    for (int unsigned i = 0; i < N_DEV; i++) begin
      if (sel_q[i]) sel_rd = sel_rd | dev_rd[i*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    be_d    = be_q;
    rd_d    = rd_q;
    err_d   = err_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pr_req) begin
          if (any_hit_c) begin
            sel_d   = hit_oh_c;
            we_d    = pr_we;
            addr_d  = pr_addr[DEC_W-1:2];
            wd_d    = pr_wd;
            be_d    = pr_be;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end else begin
            rd_d    = '0;
            err_d   = 1'b1;
            ready_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCESS: begin
        // Ack is checked before the timeout so a last-cycle ack still succeeds.
        if (sel_ack) begin
          rd_d    = we_q ? 32'd0 : sel_rd;
          err_d   = 1'b0;
          ready_d = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rd_d    = '0;
          err_d   = 1'b1;
          ready_d = 1'b1;
          sel_d   = '0;
          we_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        rd_d    = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  // Two-flop synchroniser for the asynchronous interrupt levels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dev_irq;
      sync2_q <= sync1_q;
    end
  end

  assign pr_rd    = rd_q;
  assign pr_ready = ready_q;
  assign pr_err   = err_q;
  assign dev_sel  = sel_q;
  assign dev_we   = we_q;
  assign dev_addr = addr_q;
  assign dev_wd   = wd_q;
  assign dev_be   = be_q;
  assign hw_int   = sync2_q;

endmodule

// File: doc/wait_bridge.md
# wait_bridge

Parametrised successor to the system bridge. It sits between the CPU data port and up to N_DEV memory-mapped peripherals. It decodes a programmable address window per device and registers the transaction. Slow devices can stretch the access through a per-device ack, and the bridge ends any access with an error after a bounded wait. It also synchronises and registers per-device interrupt lines into the CPU's hardware-interrupt vector.

## Interface
- N_DEV, 4: number of device channels (1..8)
- DEC_W, 8: low address bits used for per-device decode
- REGION, 24'h00007F: required value of pr_addr[31:DEC_W]; any other value is a miss
- DEV_BASE, {8'h60,8'h40,8'h20,8'h00}: packed N_DEV×DEC_W bases; slice i = device i
- DEV_MASK, {8'hE0,8'hE0,8'hE0,8'hE0}: packed N_DEV×DEC_W masks
- TIMEOUT, 16: maximum ACCESS cycles before an error; 1..255
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- pr_req  in  1  CPU access request, held until pr_ready
- pr_addr  in  32  byte address
- pr_wd  in  32  write data
- pr_we  in  1  1 = write
- pr_be  in  4  byte enables
- pr_rd  out  32  read data, valid while pr_ready
- pr_ready  out  1  one-cycle completion pulse
- pr_err  out  1  qualifies pr_ready: miss or timeout
- dev_sel  out  N_DEV  one-hot select, registered
- dev_we  out  1  registered write strobe, only with dev_sel
- dev_addr  out  DEC_W-2  word offset pr_addr[DEC_W-1:2], registered
- dev_wd  out  32  registered write data
- dev_be  out  4  registered byte enables
- dev_rd  in  N_DEV×32  packed read data
- dev_ack  in  N_DEV  per-device completion
- dev_irq  in  N_DEV  level interrupts, asynchronous to clk
- hw_int  out  N_DEV  synchronised interrupts

## Operation
- Hit rule: hit_i = (pr_addr[31:DEC_W]==REGION) && ((pr_addr[DEC_W-1:0] & MASK_i)==BASE_i).
- If more than one device hits, the lowest index wins.
- The FSM has three states: IDLE, ACCESS, DONE.
- IDLE with pr_req and a hit:
  - latch addr, wd, we and be into the dev_* registers
  - set dev_sel to the winning channel
  - clear the timeout counter
  - go to ACCESS
- IDLE with pr_req and no hit:
  - go to DONE with err=1 and rd=0
  - no dev_sel is asserted and write data is dropped
- ACCESS, each cycle:
  - if dev_ack of the selected channel is 1, capture that channel's dev_rd slice (zero for a write) and go to DONE with err=0
  - else, if the counter equals TIMEOUT-1, go to DONE with err=1 and rd=0
  - else, increment the counter
- Acks on unselected channels are ignored.
- Leaving ACCESS clears dev_sel and dev_we.
- DONE: pr_ready=1 for exactly one cycle, with pr_rd and pr_err valid; then go to IDLE unconditionally.
- pr_req is ignored outside IDLE. If pr_req is still high in the IDLE cycle after DONE, it is a new request.
- hw_int passes through a 2-flop synchroniser per bit and is independent of the FSM.

## Timing
- Reset (async, active-low) puts the FSM in IDLE and clears every output and register to 0: pr_rd, pr_ready, pr_err, dev_sel, dev_we, dev_addr, dev_wd, dev_be, hw_int and the counter.
- Reset asserted mid-access drops dev_sel immediately; no pr_ready is produced.
- Latency from the pr_req sample edge:
  - miss: pr_ready after 1 cycle
  - hit, ack in the first ACCESS cycle: pr_ready after 2 cycles
  - hit, ack in the k-th ACCESS cycle: pr_ready after k+1 cycles
  - timeout: pr_ready after TIMEOUT+1 cycles
- Ack and timeout in the same cycle: ack wins, err=0.
- dev_irq to hw_int latency is 2 cycles.

## Structure
- Package bridge_pkg holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - REGION default
  - a function that slices packed DEV_BASE/DEV_MASK
- One natural sub-module: addr_decoder. It is combinational, takes pr_addr and the parameters, and returns a one-hot hit vector with lowest-index priority plus any_hit.
- The FSM, timeout counter, registers and synchroniser stay in wait_bridge.

## Test plan
- Read hit: pr_addr=0x7F24, dev_rd[1]=0xCAFE0001, dev_ack[1] high in the first ACCESS cycle.
  - Expect dev_sel=4'b0010 and dev_addr=6'd9.
  - pr_ready 2 cycles after request, pr_rd=0xCAFE0001, pr_err=0.
- Wait states on a write: pr_addr=0x7F60, pr_we=1, pr_wd=0x12345678, pr_be=4'b0011; dev_ack[3] rises on the 5th ACCESS cycle.
  - dev_we=1 and dev_wd/dev_be stable for 5 cycles.
  - pr_ready 6 cycles after request, pr_err=0.
- Miss: pr_addr=0x7E00.
  - dev_sel stays 0.
  - pr_ready after 1 cycle, pr_err=1, pr_rd=0.
- Timeout: pr_addr=0x7F40, no ack.
  - pr_ready at cycle 17, pr_err=1, pr_rd=0.
  - A stray dev_ack[0] during the access is ignored.
- Overlap and edge case: set DEV_MASK slice 1 = 8'h00 so channel 1 matches everything.
  - Access to 0x7F10 selects channel 0 (priority).
  - Ack at counter=TIMEOUT-1 gives err=0.
- Reset mid-access and interrupts:
  - reset low during ACCESS gives dev_sel=0 immediately and no pr_ready.
  - After release, dev_irq=4'b0100 gives hw_int=4'b0100 two cycles later.
